// File: rtl/read_port_scoreboard.sv
// Single-entry decode/issue stage with a per-register pending-write scoreboard.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a RAW hazard.
module read_port_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [31:0]        in_insn,
  output logic               in_ready,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_insn,
  output logic [ADDR_W-1:0]  out_rs_a,
  output logic [ADDR_W-1:0]  out_rs_b,
  output logic [ADDR_W-1:0]  out_rd,
  output logic               out_rd_we,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rs_b;
    logic [ADDR_W-1:0] rd;
    logic              we;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] insn);
    dec_t d;
    d = '0;
    case (insn[31:27])
      5'b00000: begin
        d.rs_a = ADDR_W'(insn[21:17]);
        d.rs_b = ADDR_W'(insn[16:12]);
        d.rd   = ADDR_W'(insn[26:22]);
        d.we   = 1'b1;
      end
      5'b00101, 5'b01000: begin
        d.rs_a = ADDR_W'(insn[21:17]);
        d.rd   = ADDR_W'(insn[26:22]);
        d.we   = 1'b1;
      end
      5'b00111: begin
        d.rs_a = ADDR_W'(insn[21:17]);
        d.rs_b = ADDR_W'(insn[26:22]);
      end
      5'b00100: d.rs_a = ADDR_W'(insn[26:22]);
      5'b00010, 5'b00110: begin
        d.rs_a = ADDR_W'(insn[26:22]);
        d.rs_b = ADDR_W'(insn[21:17]);
      end
      5'b10110: d.rs_a = ADDR_W'(30);
      5'b00011: begin
        d.rd = ADDR_W'(31);
        d.we = 1'b1;
      end
      5'b10101: begin
        d.rd = ADDR_W'(30);
        d.we = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p1: held instruction; vld_p1 is the "full" flag
  logic              vld_p1;
  logic [31:0]       insn_p1;
  logic [ADDR_W-1:0] rs_a_p1, rs_b_p1, rd_p1;
  logic              we_p1;
  logic              ready_en;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_eff [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec, dec_vec;
  logic [STALL_W-1:0]  stall_cnt;
  logic                stall, issue, accept;
  dec_t                in_dec;

  assign in_dec = decode(in_insn);

  // Writeback against an idle counter is ignored, so it never underflows
  always_comb begin
    dec_vec = '0;
    for (int i = 1; i < NUM_REGS; i++)
      dec_vec[i] = wb_valid && (wb_addr == ADDR_W'(i)) && (cnt[i] != '0);
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_eff[i] = cnt[i];
`ifdef SCOREBOARD_WB_BYPASS_EN
      if (dec_vec[i]) cnt_eff[i] = cnt[i] - 1'b1;
`endif
    end
  end

  always_comb begin
    stall = ((rs_a_p1 != '0) && (cnt_eff[rs_a_p1] != '0)) ||
            ((rs_b_p1 != '0) && (cnt_eff[rs_b_p1] != '0)) ||
            (we_p1 && (cnt_eff[rd_p1] == CNT_MAX));
  end

  assign out_valid = vld_p1 && !stall && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = ready_en && !flush && (!vld_p1 || issue);
  assign accept    = in_valid && in_ready;

  always_comb begin
    inc_vec = '0;
    for (int i = 1; i < NUM_REGS; i++)
      inc_vec[i] = issue && we_p1 && (rd_p1 == ADDR_W'(i));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1    <= 1'b0;
      ready_en  <= 1'b0;
      stall_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept)              vld_p1 <= 1'b1;
      else if (flush || issue) vld_p1 <= 1'b0;
      if (vld_p1 && stall) stall_cnt <= sat_inc(stall_cnt);
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Payload only moves on accept, which keeps it stable while stalled or backpressured
  always_ff @(posedge clock) begin
    if (accept) begin
      insn_p1 <= in_insn;
      rs_a_p1 <= in_dec.rs_a;
      rs_b_p1 <= in_dec.rs_b;
      rd_p1   <= in_dec.rd;
      we_p1   <= in_dec.we;
    end
  end

  assign out_insn     = insn_p1;
  assign out_rs_a     = rs_a_p1;
  assign out_rs_b     = rs_b_p1;
  assign out_rd       = rd_p1;
  assign out_rd_we    = we_p1;
  assign stall_cycles = stall_cnt;

endmodule

// File: doc/read_port_scoreboard.md
READ_PORT_SCOREBOARD -- requirements
Module: read_port_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: architectural register count; ADDR_W = clog2(NUM_REGS).
REQ-002 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-003 SHALL have parameter STALL_W, default 16: width of the stall-cycle counter.
REQ-004 SHALL have ports:
  - clock  in  1  sole clock; all state updates on the rising edge.
  - reset_n  in  1  reset, asynchronous, active-low.
  - in_valid  in  1  offered instruction is valid.
  - in_insn  in  32  offered instruction.
  - in_ready  out  1  stage can accept an instruction this cycle.
  - flush  in  1  discard the held instruction.
  - wb_valid  in  1  writeback retires one write this cycle.
  - wb_addr  in  ADDR_W  writeback destination register.
  - out_valid  out  1  held instruction is hazard-free and issuable.
  - out_ready  in  1  downstream accepts the issue.
  - out_insn  out  32  held instruction.
  - out_rs_a, out_rs_b  out  ADDR_W each  decoded read addresses.
  - out_rd  out  ADDR_W  decoded destination address.
  - out_rd_we  out  1  held instruction writes out_rd.
  - stall_cycles  out  STALL_W  saturating count of hazard-stall cycles.

Function
REQ-005 SHALL decode in_insn[31:27] as follows:
  - 00000 (R-type): A = [21:17], B = [16:12], rd = [26:22], writes.
  - 00101 addi and 01000 lw: A = [21:17], B = 0, rd = [26:22], writes.
  - 00111 sw: A = [21:17], B = [26:22], no write.
  - 00100 jr: A = [26:22], B = 0, no write.
  - 00010 bne and 00110 blt: A = [26:22], B = [21:17], no write.
  - 10110 bex: A = 30, B = 0, no write.
  - 00011 jal: A = 0, B = 0, rd = 31, writes.
  - 10101 setx: A = 0, B = 0, rd = 30, writes.
  - All other opcodes: A = 0, B = 0, no write.
REQ-006 SHALL register the decode into a single-entry stage on in_valid && in_ready; latency from input to out_valid is 1 cycle minimum.
REQ-007 SHALL drive in_ready = !full || (out_valid && out_ready), with no combinational path from in_valid to in_ready.
REQ-008 SHALL keep one CNT_W-bit pending counter per register; register 0 is never pending and writes to it are never counted.
REQ-009 SHALL stall when the held A or B is nonzero with a nonzero counter, or when out_rd_we is set and the out_rd counter is at its maximum (2^CNT_W - 1).
REQ-010 SHALL assert out_valid = full && !stall && !flush.
REQ-011 SHALL keep all out_* fields stable while out_valid is high and out_ready is low.
REQ-012 SHALL increment counter[out_rd] on an issue (out_valid && out_ready && out_rd_we && out_rd != 0).
REQ-013 SHALL decrement counter[wb_addr] on wb_valid when wb_addr != 0; wb_valid against a zero counter is ignored and the counter stays at 0.
REQ-014 SHALL leave the counter unchanged when an increment and a decrement hit the same register in one cycle.
REQ-015 SHALL, on flush, empty the stage next cycle and block acceptance of in_valid that cycle (in_ready = 0); flush does not alter the counters.
REQ-016 SHALL increment stall_cycles each cycle that full && stall holds, saturating at all-ones.

Reset
REQ-017 SHALL, while reset_n is low, asynchronously force: stage empty, all counters 0, stall_cycles 0, out_valid 0, in_ready 0.
REQ-018 SHALL drive in_ready 1 from the first clock edge after reset_n deasserts; an instruction in flight at reset is dropped.

Configuration
REQ-019 SHALL support macro SCOREBOARD_WB_BYPASS_EN:
  - Defined: a same-cycle wb_valid decrement is used in the REQ-009 hazard check, so a counter at 1 whose writeback arrives this cycle does not stall.
  - Undefined: the hazard check uses registered counter values only, giving one extra stall cycle.

Verification
REQ-020 SHALL cover these directed scenarios:
  - Issue add r3 = r1 + r2, then add r4 = r3 + r3; no wb -> second instruction holds out_valid = 0 and stall_cycles increments every cycle.
  - Same sequence, then wb_valid with wb_addr = 3 -> bypass build issues in that cycle; non-bypass build issues the next cycle.
  - Issue 3 writes to r5 with CNT_W = 2, no wb -> 4th write to r5 stalls (counter = 3).
  - Issue a write to r7 and wb_valid with wb_addr = 7 in the same cycle while the counter is 1 -> counter stays 1.
  - Decode checks: bex -> rs_a = 30; jal -> rd = 31 with we = 1; sw r9, 0(r2) -> rs_a = 2, rs_b = 9, we = 0; write to r0 -> never counted.
  - Assert flush while stalled, then pulse reset_n low mid-stream -> stage empties, counters unchanged after flush; all outputs reach reset values asynchronously.
